// File: rtl/brg_slave_xcel_gcd_array.sv
// Array of independent iterative GCD engines behind a manycore slave port.
// Each channel exposes an 8-word CSR window: OPA, OPB, GO, STATUS, RESULT, CYCLES.
module brg_slave_xcel_gcd_array #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned num_chan_p   = 4,
  parameter bit          block_go_p   = 1'b1,
  parameter int unsigned cyc_width_p  = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      in_v_i,
  input  logic [addr_width_p-1:0]   in_addr_i,
  input  logic [data_width_p-1:0]   in_data_i,
  input  logic [data_width_p/8-1:0] in_mask_i,
  input  logic                      in_we_i,
  output logic                      in_yumi_o,
  output logic                      returning_v_o,
  output logic [data_width_p-1:0]   returning_data_o,
  output logic [num_chan_p-1:0]     busy_o
);

  localparam int unsigned MaskW = data_width_p / 8;
  localparam logic [cyc_width_p-1:0] CycOne = cyc_width_p'(1);

  localparam logic [2:0] RegOpa    = 3'd0;
  localparam logic [2:0] RegOpb    = 3'd1;
  localparam logic [2:0] RegGo     = 3'd2;
  localparam logic [2:0] RegStatus = 3'd3;
  localparam logic [2:0] RegResult = 3'd4;
  localparam logic [2:0] RegCycles = 3'd5;

  typedef enum logic {StIdle, StCalc} state_e;

  // Per-channel state
  state_e                  state_q [num_chan_p];
  logic [data_width_p-1:0] opa_q   [num_chan_p];
  logic [data_width_p-1:0] opb_q   [num_chan_p];
  logic [data_width_p-1:0] a_q     [num_chan_p];
  logic [data_width_p-1:0] b_q     [num_chan_p];
  logic [data_width_p-1:0] res_q   [num_chan_p];
  logic [cyc_width_p-1:0]  cyc_q   [num_chan_p];
  logic [num_chan_p-1:0]   done_q;
  logic [num_chan_p-1:0]   err_q;

  // Response path
  logic                    ret_v_q;
  logic [data_width_p-1:0] ret_data_q;
  logic [data_width_p-1:0] rdata_d;

  // Request decode
  logic [3:0]            chan;
  logic [2:0]            regsel;
  logic                  hi_zero;
  logic                  mapped;
  logic [num_chan_p-1:0] sel;
  logic                  sel_busy;
  logic                  is_go;
  logic                  stall;
  logic [num_chan_p-1:0] wr_hit;
  logic [num_chan_p-1:0] rd_hit;
  logic [num_chan_p-1:0] go_hit;

  assign chan    = in_addr_i[6:3];
  assign regsel  = in_addr_i[2:0];
  assign hi_zero = ((in_addr_i >> 7) == '0);
  assign mapped  = hi_zero && ({28'd0, chan} < num_chan_p);

  always_comb begin
    sel = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      sel[c] = mapped && (chan == 4'(c));
    end
  end

  always_comb begin
    for (int c = 0; c < num_chan_p; c++) begin
      busy_o[c] = (state_q[c] == StCalc);
    end
  end

  assign sel_busy  = |(sel & busy_o);
  assign is_go     = in_v_i && in_we_i && (regsel == RegGo);
  // Only a GO aimed at a running engine can hold off the requester.
  assign stall     = block_go_p && is_go && sel_busy;
  assign in_yumi_o = in_v_i && !stall;

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    go_hit = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      wr_hit[c] = in_yumi_o && in_we_i && sel[c];
      rd_hit[c] = in_yumi_o && !in_we_i && sel[c];
      go_hit[c] = wr_hit[c] && (regsel == RegGo);
    end
  end

  // Read mux samples pre-update register state; writes and unmapped reads return zero.
  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      if (rd_hit[c]) begin
        unique case (regsel)
          RegOpa:    rdata_d = opa_q[c];
          RegOpb:    rdata_d = opb_q[c];
          RegStatus: rdata_d = {{(data_width_p-3){1'b0}}, err_q[c], done_q[c], busy_o[c]};
          RegResult: rdata_d = res_q[c];
          RegCycles: rdata_d = data_width_p'(cyc_q[c]);
          default:   rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ret_v_q    <= 1'b0;
      ret_data_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
      for (int c = 0; c < num_chan_p; c++) begin
        state_q[c] <= StIdle;
        opa_q[c]   <= '0;
        opb_q[c]   <= '0;
        a_q[c]     <= '0;
        b_q[c]     <= '0;
        res_q[c]   <= '0;
        cyc_q[c]   <= '0;
      end
    end else begin
      ret_v_q    <= in_yumi_o;
      ret_data_q <= rdata_d;
      for (int c = 0; c < num_chan_p; c++) begin
        // Byte-masked operand CSR writes; the engine copy is untouched.
        if (wr_hit[c] && (regsel == RegOpa)) begin
          for (int b = 0; b < MaskW; b++) begin
            if (in_mask_i[b]) opa_q[c][8*b +: 8] <= in_data_i[8*b +: 8];
          end
        end
        if (wr_hit[c] && (regsel == RegOpb)) begin
          for (int b = 0; b < MaskW; b++) begin
            if (in_mask_i[b]) opb_q[c][8*b +: 8] <= in_data_i[8*b +: 8];
          end
        end

        // Read-clear comes first so a same-cycle completion below overrides it.
        if (rd_hit[c] && (regsel == RegResult)) done_q[c] <= 1'b0;

        unique case (state_q[c])
          StIdle: begin
            if (go_hit[c]) begin
              a_q[c]     <= opa_q[c];
              b_q[c]     <= opb_q[c];
              done_q[c]  <= 1'b0;
              err_q[c]   <= 1'b0;
              cyc_q[c]   <= '0;
              state_q[c] <= StCalc;
            end
          end
          StCalc: begin
            if (cyc_q[c] != '1) cyc_q[c] <= cyc_q[c] + CycOne;
            if (a_q[c] < b_q[c]) begin
              a_q[c] <= b_q[c];
              b_q[c] <= a_q[c];
            end else if (b_q[c] != '0) begin
              a_q[c] <= a_q[c] - b_q[c];
            end else begin
              res_q[c]   <= a_q[c];
              done_q[c]  <= 1'b1;
              state_q[c] <= StIdle;
            end
            // Reachable only in drop mode; blocking mode stalls such a GO.
            if (go_hit[c]) err_q[c] <= 1'b1;
          end
          default: state_q[c] <= StIdle;
        endcase
      end
    end
  end

  assign returning_v_o    = ret_v_q;
  assign returning_data_o = ret_data_q;

endmodule
